priority_scan_encoder: RTL



---
 rtl/priority_scan_encoder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/priority_scan_encoder.sv
// priority_scan_encoder
// Accepts a request vector over a valid/ready handshake and then emits the
// index of every set bit, one per output handshake, in priority order.
// MSB_FIRST=0 gives bit 0 the highest priority; MSB_FIRST=1 gives bit WIDTH-1.
module priority_scan_encoder #(
    parameter int unsigned WIDTH     = 16,
    parameter bit          MSB_FIRST = 1'b0,
    localparam int unsigned IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             out_none,
    output logic             busy
);

    if (WIDTH < 2 || WIDTH > 256) begin : g_width_check
        $error("priority_scan_encoder: WIDTH must be in 2..256");
    end

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] w_pending_nxt;
    logic             r_none;
    logic             w_none_nxt;

    logic [WIDTH-1:0] w_sel;
    logic [IDX_W-1:0] w_idx;
    logic             w_onehot;
    logic             w_scan;
    logic             w_in_hs;
    logic             w_out_hs;

    // Highest-priority pending bit: index and one-hot mask (last hit in the loop wins)
    always_comb begin
        w_idx = '0;
        w_sel = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST) begin
                if (r_pending[i]) begin
                    w_idx    = IDX_W'(i);
                    w_sel    = '0;
                    w_sel[i] = 1'b1;
                end
            end else begin
                if (r_pending[WIDTH-1-i]) begin
                    w_idx              = IDX_W'(WIDTH-1-i);
                    w_sel              = '0;
                    w_sel[WIDTH-1-i]   = 1'b1;
                end
            end
        end
    end

    // A vector has exactly one bit left when it equals its own selected bit
    assign w_onehot = (r_pending != '0) && (r_pending == w_sel);

    assign w_scan   = (r_state == ST_SCAN);
    assign w_in_hs  = in_valid && !w_scan;
    assign w_out_hs = w_scan && out_ready;

    assign in_ready  = !w_scan;
    assign out_valid = w_scan;
    assign busy      = w_scan;
    assign out_idx   = w_scan ? w_idx : '0;
    assign out_last  = w_scan && w_onehot;
    assign out_none  = r_none;

    // Next-state, next-pending and zero-vector pulse
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_none_nxt    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_in_hs) begin
                    if (in_vec != '0) begin
                        w_pending_nxt = in_vec;
                        w_state_nxt   = ST_SCAN;
                    end else begin
                        w_none_nxt = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                if (w_out_hs) begin
                    w_pending_nxt = r_pending & ~w_sel;
                    if (w_onehot) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_pending_nxt = '0;
            end
        endcase
    end

    // State, pending vector and out_none registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_none    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_none    <= w_none_nxt;
        end
    end

endmodule
